scan_clock_divider: RTL and testbench
=====================================

SCAN_CLOCK_DIVIDER -- requirements
Module: scan_clock_divider

Interface
REQ-001 The module SHALL have parameter DIV_WIDTH, default 17, which sets the width of the half-period count and the half_period input.
REQ-002 The module SHALL have parameter DEFAULT_HALF, default 50000, which sets the half-period in clock cycles after reset; legal range 1..2^DIV_WIDTH-1.
REQ-003 Port clock  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 Port enable  input  1  1 = counting; 0 = freeze the count and div_clock level.
REQ-006 Port load  input  1  single-cycle strobe that requests a new half-period.
REQ-007 Port half_period  input  DIV_WIDTH  requested half-period in clock cycles; sampled only when load=1.
REQ-008 Port div_clock  output  1  registered scan clock with 50% duty; this output drives seven_seg_scanner.div_clock.
REQ-009 Port tick  output  1  one-cycle pulse that is 1 in the same cycle in which div_clock goes 0->1.
REQ-010 Port update_pending  output  1  1 while a loaded half-period waits to become active.

Function
REQ-011 The module SHALL hold internal registers: count (DIV_WIDTH), active_half (DIV_WIDTH), shadow_half (DIV_WIDTH) and pending (1).
REQ-012 When enable=1 and count != active_half-1, count SHALL increment by 1.
REQ-013 When enable=1 and count == active_half-1 (a "wrap" cycle), the module SHALL:
- set count to 0;
- toggle div_clock;
- if pending=1, copy shadow_half into active_half and clear pending.
REQ-014 tick SHALL be registered and SHALL equal 1 exactly when a wrap toggles div_clock from 0 to 1; it SHALL be 0 in every other cycle.
REQ-015 With a constant active_half H, div_clock SHALL have period 2*H clock cycles, high for H cycles and low for H cycles.
REQ-016 load=1 on a non-wrap cycle SHALL set shadow_half to max(half_period,1) and set pending to 1; this SHALL be accepted regardless of enable.
REQ-017 load=1 on a wrap cycle SHALL write max(half_period,1) directly into active_half, leave pending at 0, and govern the half-period that starts in that cycle.
REQ-018 load=1 while pending=1 SHALL overwrite shadow_half; only the last loaded value SHALL take effect.
REQ-019 half_period=0 SHALL be treated as 1, which makes div_clock toggle on every enabled clock.
REQ-020 When enable=0:
- count, div_clock, active_half and pending SHALL hold their values, except that a load updates shadow_half and pending per REQ-016;
- tick SHALL be 0.
REQ-021 update_pending SHALL equal the pending register.
REQ-022 count SHALL never exceed active_half-1; a new active_half SHALL take effect only when count returns to 0.

Reset
REQ-023 While reset=0 the module SHALL asynchronously force: count=0, div_clock=0, tick=0, active_half=DEFAULT_HALF, shadow_half=DEFAULT_HALF, pending=0.
REQ-024 An assertion of reset mid-period SHALL discard any pending update.
REQ-025 After reset deasserts, counting SHALL resume on the first rising clock edge with enable=1, starting from count=0.

Verification (bench uses DEFAULT_HALF=4; cycles counted from the first enabled edge after reset release)
REQ-026 Reset release with enable=1 held -> div_clock toggles 0->1 at cycle 4, 1->0 at cycle 8, 0->1 at cycle 12; tick=1 only at cycles 4 and 12; period = 8.
REQ-027 load=1 with half_period=2 at cycle 2 -> update_pending=1 through cycle 3; the current half completes at cycle 4 with length 4; from then on div_clock toggles every 2 cycles and update_pending=0.
REQ-028 load=1 with half_period=0 -> after the next wrap, div_clock toggles every clock and tick pulses every 2 cycles.
REQ-029 enable=0 for 3 cycles starting at cycle 1 -> the next edge moves from cycle 4 to cycle 7; tick=0 while enable=0; the div_clock level holds.
REQ-030 load=1 with half_period=6 exactly on a wrap cycle -> the new half lasts 6 cycles immediately and update_pending stays 0.
REQ-031 reset pulsed low mid-period with update_pending=1 -> div_clock=0, tick=0 and update_pending=0 immediately (asynchronously); after release the REQ-026 timing repeats with half=4.

Source files
------------

// File: rtl/scan_clock_divider.sv
// Programmable 50%-duty scan clock divider with a shadowed half-period that
// is committed at the next wrap, so a reload never produces a runt pulse.
module scan_clock_divider #(
  parameter int unsigned DIV_WIDTH    = 17,
  parameter int unsigned DEFAULT_HALF = 50000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] half_period,
  output logic                 div_clock,
  output logic                 tick,
  output logic                 update_pending
);

  localparam logic [DIV_WIDTH-1:0] HALF_RST = DIV_WIDTH'(DEFAULT_HALF);
  localparam logic [DIV_WIDTH-1:0] ONE      = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] count_q, count_d;
  logic [DIV_WIDTH-1:0] active_half_q, active_half_d;
  logic [DIV_WIDTH-1:0] shadow_half_q, shadow_half_d;
  logic                 pending_q, pending_d;
  logic                 div_clock_q, div_clock_d;
  logic                 tick_q, tick_d;
  logic [DIV_WIDTH-1:0] load_val;
  logic                 wrap;

  // A zero request is clamped to 1 so active_half-1 can never underflow.
  assign load_val = (half_period == '0) ? ONE : half_period;
  assign wrap     = enable && (count_q == (active_half_q - ONE));

  always_comb begin
    count_d       = count_q;
    active_half_d = active_half_q;
    shadow_half_d = shadow_half_q;
    pending_d     = pending_q;
    div_clock_d   = div_clock_q;
    tick_d        = 1'b0;

    if (enable) begin
      if (wrap) begin
        count_d     = '0;
        div_clock_d = ~div_clock_q;
        tick_d      = ~div_clock_q;
        if (pending_q) begin
          active_half_d = shadow_half_q;
          pending_d     = 1'b0;
        end
      end else begin
        count_d = count_q + ONE;
      end
    end

    // A load landing on a wrap governs the half that starts right now.
    if (load) begin
      if (wrap) begin
        active_half_d = load_val;
        pending_d     = 1'b0;
      end else begin
        shadow_half_d = load_val;
        pending_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q       <= '0;
      active_half_q <= HALF_RST;
      shadow_half_q <= HALF_RST;
      pending_q     <= 1'b0;
      div_clock_q   <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      count_q       <= count_d;
      active_half_q <= active_half_d;
      shadow_half_q <= shadow_half_d;
      pending_q     <= pending_d;
      div_clock_q   <= div_clock_d;
      tick_q        <= tick_d;
    end
  end

  assign div_clock      = div_clock_q;
  assign tick           = tick_q;
  assign update_pending = pending_q;

endmodule

// File: tb/tb_scan_clock_divider.sv
// Directed bench for scan_clock_divider with DEFAULT_HALF=4; expected waveforms
// are hand-written strings, one character per enabled-or-not clock edge.
module tb_scan_clock_divider;

  localparam int DW = 17;

  logic          clock;
  logic          reset;
  logic          enable;
  logic          load;
  logic [DW-1:0] half_period;
  logic          div_clock;
  logic          tick;
  logic          update_pending;

  int total  = 0;
  int passed = 0;

  scan_clock_divider #(.DIV_WIDTH(DW), .DEFAULT_HALF(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .load           (load),
    .half_period    (half_period),
    .div_clock      (div_clock),
    .tick           (tick),
    .update_pending (update_pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
  endtask

  // Each character of dv/tk/pd is the expected value after one more edge.
  task automatic run_seq(input string tag, input string dv, input string tk, input string pd);
    for (int i = 0; i < dv.len(); i++) begin
      step();
      chk($sformatf("%s[%0d]_div", tag, i), div_clock, dv.getc(i) == "1");
      chk($sformatf("%s[%0d]_tick", tag, i), tick, tk.getc(i) == "1");
      chk($sformatf("%s[%0d]_pend", tag, i), update_pending, pd.getc(i) == "1");
    end
  endtask

  task automatic reset_cycle(input string tag);
    reset = 1'b0;
    #1;
    chk({tag, "_rst_div"}, div_clock, 1'b0);
    chk({tag, "_rst_tick"}, tick, 1'b0);
    chk({tag, "_rst_pend"}, update_pending, 1'b0);
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    enable      = 1'b1;
    load        = 1'b0;
    half_period = '0;
    step();

    // Basic timing: toggles at 4, 8, 12; tick at 4 and 12.
    reset_cycle("base");
    run_seq("base", "0001111000011", "0001000000010", "0000000000000");

    // Load 2 at cycle 2: pending through 3, commit at wrap 4.
    reset_cycle("ld2");
    run_seq("ld2a", "0", "0", "0");
    load = 1'b1; half_period = DW'(2);
    run_seq("ld2b", "0", "0", "1");
    load = 1'b0;
    run_seq("ld2c", "01100110", "01000100", "10000000");

    // Load 0 acts as 1: toggles every clock after the next wrap.
    reset_cycle("ld0");
    load = 1'b1; half_period = '0;
    run_seq("ld0a", "0", "0", "1");
    load = 1'b0;
    run_seq("ld0b", "0010101", "0010101", "1100000");

    // Enable low freezes the count, level and tick; loads still land in shadow.
    reset_cycle("en");
    run_seq("en_a", "0", "0", "0");
    enable = 1'b0;
    run_seq("en_off1", "000", "000", "000");
    enable = 1'b1;
    run_seq("en_b", "001", "001", "000");
    enable = 1'b0;
    load = 1'b1; half_period = DW'(2);
    run_seq("en_off2", "1", "0", "1");
    load = 1'b0;
    run_seq("en_off3", "1", "0", "1");
    enable = 1'b1;
    run_seq("en_c", "111001", "000001", "111000");

    // Load 6 on the wrap cycle takes effect immediately, no pending.
    reset_cycle("wr6");
    run_seq("wr6a", "000", "000", "000");
    load = 1'b1; half_period = DW'(6);
    run_seq("wr6b", "1", "1", "0");
    load = 1'b0;
    run_seq("wr6c", "1111100", "0000000", "0000000");
    run_seq("wr6d", "00001", "00001", "00000");

    // Mid-period reset with a pending update discards it asynchronously.
    reset_cycle("ar");
    run_seq("ar_a", "00011", "00010", "00000");
    load = 1'b1; half_period = DW'(2);
    run_seq("ar_b", "1", "0", "1");
    load = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("ar_async_div", div_clock, 1'b0);
    chk("ar_async_tick", tick, 1'b0);
    chk("ar_async_pend", update_pending, 1'b0);
    step();
    step();
    reset = 1'b1;
    run_seq("ar_c", "0001111000011", "0001000000010", "0000000000000");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
